writeback_stage: RTL and testbench

- Final MIPS32 pipeline stage: the write side of the register bank that the decode stage reads.
- Captures the MEM/WB latch (IR, ALU result, LMD) through a valid/ready handshake.
- Selects the result by opcode and drives a single register-file write port.
- Keeps sticky HALT/illegal status and a retire counter.

---
 rtl/mips32_pkg.sv | 38 +++
 rtl/wb_classify.sv | 27 ++
 rtl/writeback_stage.sv | 93 +++++++++
 tb/tb_writeback_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - MIPS32 opcodes, instruction classes and IR field positions
package mips32_pkg;

    localparam logic [5:0] OP_ADD   = 6'h00;
    localparam logic [5:0] OP_SUB   = 6'h01;
    localparam logic [5:0] OP_AND   = 6'h02;
    localparam logic [5:0] OP_OR    = 6'h03;
    localparam logic [5:0] OP_SLT   = 6'h04;
    localparam logic [5:0] OP_MUL   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h08;
    localparam logic [5:0] OP_SW    = 6'h09;
    localparam logic [5:0] OP_ADDI  = 6'h0A;
    localparam logic [5:0] OP_SUBI  = 6'h0B;
    localparam logic [5:0] OP_SLTI  = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D;
    localparam logic [5:0] OP_BEQZ  = 6'h0E;
    localparam logic [5:0] OP_HLT   = 6'h3F;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RD_MSB = 25;
    localparam int RD_LSB = 21;

    typedef enum logic [2:0] {
        CLS_RR,
        CLS_IMM,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic logic class_writes(input instr_class_e cls);
        return (cls == CLS_RR) || (cls == CLS_IMM) || (cls == CLS_LOAD);
    endfunction

endpackage

// File: rtl/wb_classify.sv
// rtl/wb_classify.sv - opcode to instruction class and register-write decision
module wb_classify
    import mips32_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [4:0]   rd,
    output instr_class_e cls,
    output logic         needs_write
);

    always_comb begin
        cls = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = CLS_RR;
            OP_ADDI, OP_SUBI, OP_SLTI:                     cls = CLS_IMM;
            OP_LW:                                         cls = CLS_LOAD;
            OP_SW:                                         cls = CLS_STORE;
            OP_BNEQZ, OP_BEQZ:                             cls = CLS_BRANCH;
            OP_HLT:                                        cls = CLS_HALT;
            default:                                       cls = CLS_ILLEGAL;
        endcase
    end

    // r0 is hardwired to zero, so writes to it are dropped here
    assign needs_write = class_writes(cls) && (rd != 5'd0);

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MIPS32 write-back stage driving the register-file write port
module writeback_stage
    import mips32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  ir_mem,
    input  logic [XLEN-1:0]  alu_out_mem,
    input  logic [XLEN-1:0]  lmd_mem,
    input  logic             wb_ready,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [XLEN-1:0]  wb_data,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retire_count
);

    instr_class_e in_cls;
    logic         in_needs_write;

    wb_classify u_classify (
        .opcode      (ir_mem[OP_MSB:OP_LSB]),
        .rd          (ir_mem[RD_MSB:RD_LSB]),
        .cls         (in_cls),
        .needs_write (in_needs_write)
    );

    // Only opcode and rd matter once the result is latched
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir_mem[RD_LSB-1:0];

    logic            occupied;
    logic            needs_write_q;
    instr_class_e    cls_q;
    logic [4:0]      addr_q;
    logic [XLEN-1:0] data_q;

    logic retiring;
    logic halt_pending;
    logic capture;

    assign retiring     = occupied && (!needs_write_q || wb_ready);
    assign halt_pending = occupied && (cls_q == CLS_HALT);
    assign in_ready     = !halted && !halt_pending && (!occupied || retiring);
    assign capture      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupied      <= 1'b0;
            needs_write_q <= 1'b0;
            cls_q         <= CLS_RR;
            addr_q        <= '0;
            data_q        <= '0;
        end else begin
            if (capture) begin
                occupied      <= 1'b1;
                needs_write_q <= in_needs_write;
                cls_q         <= in_cls;
                addr_q        <= ir_mem[RD_MSB:RD_LSB];
                data_q        <= (in_cls == CLS_LOAD) ? lmd_mem : alu_out_mem;
            end else if (retiring) begin
                occupied <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted       <= 1'b0;
            illegal      <= 1'b0;
            retire_count <= '0;
        end else if (retiring) begin
            retire_count <= retire_count + 1'b1;
            if (cls_q == CLS_HALT) begin
                halted <= 1'b1;
            end
            if (cls_q == CLS_ILLEGAL) begin
                illegal <= 1'b1;
            end
        end
    end

    assign wb_en   = occupied && needs_write_q;
    assign wb_addr = addr_q;
    assign wb_data = data_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ir_mem;
    logic [31:0] alu_out_mem;
    logic [31:0] lmd_mem;
    logic        wb_ready;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        halted;
    logic        illegal;
    logic [31:0] retire_count;

    int n_checks = 0;
    int n_pass   = 0;

    writeback_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ir_mem       (ir_mem),
        .alu_out_mem  (alu_out_mem),
        .lmd_mem      (lmd_mem),
        .wb_ready     (wb_ready),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .halted       (halted),
        .illegal      (illegal),
        .retire_count (retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rd);
        return {op, rd, 21'h1ABCD};
    endfunction

    task automatic present(input logic [5:0] op, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] lmd);
        in_valid    = 1'b1;
        ir_mem      = mk_ir(op, rd);
        alu_out_mem = alu;
        lmd_mem     = lmd;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_wb_en"},   wb_en, 0);
        check({tag, "_wb_addr"}, wb_addr, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_halted"},  halted, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_count"},   retire_count, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        ir_mem      = '0;
        alu_out_mem = '0;
        lmd_mem     = '0;
        wb_ready    = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);

        // ADD rd=5; IR word must equal 0x00A0_0000 in its upper fields
        present(6'h00, 5'd5, 32'h1234, 32'h5555);
        check("add_ir_rd", {32'h0, ir_mem[25:21]}, 5);
        @(negedge clk);
        in_valid = 1'b0;
        check("add_wb_en", wb_en, 1);
        check("add_wb_addr", wb_addr, 5);
        check("add_wb_data", wb_data, 32'h1234);
        check("add_count_pre", retire_count, 0);
        @(negedge clk);
        check("add_count", retire_count, 1);
        check("add_wb_en_off", wb_en, 0);

        // LW picks the load data, not the address
        present(6'h08, 5'd3, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        in_valid = 1'b0;
        check("lw_wb_en", wb_en, 1);
        check("lw_wb_addr", wb_addr, 3);
        check("lw_wb_data", wb_data, 32'hDEADBEEF);
        @(negedge clk);
        check("lw_count", retire_count, 2);

        // ADDI to r0 retires silently
        present(6'h0A, 5'd0, 32'h99, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        check("addi_r0_wb_en", wb_en, 0);
        @(negedge clk);
        check("addi_r0_wb_en2", wb_en, 0);
        check("addi_r0_count", retire_count, 3);

        // Stall: ADD rd=7 held for 3 cycles while ADD rd=9 waits upstream
        present(6'h00, 5'd7, 32'h77, 32'h0);
        @(negedge clk);
        wb_ready = 1'b0;
        present(6'h00, 5'd9, 32'h99, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_wb_en", wb_en, 1);
            check("stall_wb_addr", wb_addr, 7);
            check("stall_wb_data", wb_data, 32'h77);
            check("stall_in_ready", in_ready, 0);
            check("stall_count", retire_count, 3);
            @(negedge clk);
        end
        wb_ready = 1'b1;
        #1;
        check("stall_release_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("stall_next_wb_en", wb_en, 1);
        check("stall_next_wb_addr", wb_addr, 9);
        check("stall_next_wb_data", wb_data, 32'h99);
        check("stall_next_count", retire_count, 4);
        @(negedge clk);
        check("stall_done_count", retire_count, 5);

        // 4 ALU ops back to back, then HLT, then SW which must never enter
        for (int k = 0; k < 6; k++) begin
            if (k >= 1 && k <= 4) begin
                check("stream_wb_en", wb_en, 1);
                check("stream_wb_addr", wb_addr, k);
                check("stream_wb_data", wb_data, 32'h100 + k);
            end
            if (k < 4)       present(6'h01, 5'(k + 1), 32'h101 + k, 32'h0);
            else if (k == 4) present(6'h3F, 5'd0, 32'h0, 32'h0);
            else             present(6'h09, 5'd2, 32'hBAD, 32'h0);
            if (k == 5) begin
                #1;
                check("hlt_pending_in_ready", in_ready, 0);
                check("hlt_pending_halted", halted, 0);
                check("hlt_pending_wb_en", wb_en, 0);
            end
            @(negedge clk);
        end
        check("hlt_halted", halted, 1);
        check("hlt_count", retire_count, 10);
        repeat (3) @(negedge clk);
        check("hlt_in_ready", in_ready, 0);
        check("hlt_sw_no_write", wb_en, 0);
        check("hlt_count_hold", retire_count, 10);
        check("hlt_illegal", illegal, 0);

        // Asynchronous reset clears the halt
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("hlt_reset_halted", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Unknown opcode 0x20: no write, sticky illegal, no stall
        present(6'h20, 5'd4, 32'h4444, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        check("ill_wb_en", wb_en, 0);
        check("ill_in_ready", in_ready, 1);
        @(negedge clk);
        check("ill_flag", illegal, 1);
        check("ill_count", retire_count, 1);
        check("ill_in_ready2", in_ready, 1);

        // Reset in the middle of a stall drops the held write
        wb_ready = 1'b0;
        present(6'h00, 5'd7, 32'h77, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_stall_wb_en", wb_en, 1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        check("post_rst_wb_en", wb_en, 0);
        check("post_rst_count", retire_count, 0);
        check("post_rst_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
